// File: rtl/fifo_n_level_if.sv
// fifo_n_level_if: ENQ/DEQ/CLR handshake and status bundle for fifo_n_level
// master: producer/consumer side (drives D_IN, ENQ, DEQ, CLR; sees data and status)
// slave: the FIFO (drives D_OUT, FULL_N, EMPTY_N, COUNT, ALMOST_FULL, ALMOST_EMPTY)
// FIFON_ERR_FLAGS_EN adds sticky OVF/UDF to the bundle
interface fifo_n_level_if #(
  parameter int width = 1,
  parameter int depth = 4
);
  logic [width-1:0] D_IN, D_OUT;
  logic ENQ, DEQ, CLR;
  logic FULL_N, EMPTY_N, ALMOST_FULL, ALMOST_EMPTY;
  logic [$clog2(depth+1)-1:0] COUNT;
`ifdef FIFON_ERR_FLAGS_EN
  logic OVF, UDF;
  modport master(output D_IN, ENQ, DEQ, CLR,
                 input D_OUT, FULL_N, EMPTY_N, COUNT, ALMOST_FULL, ALMOST_EMPTY, OVF, UDF);
  modport slave(input D_IN, ENQ, DEQ, CLR,
                output D_OUT, FULL_N, EMPTY_N, COUNT, ALMOST_FULL, ALMOST_EMPTY, OVF, UDF);
`else
  modport master(output D_IN, ENQ, DEQ, CLR,
                 input D_OUT, FULL_N, EMPTY_N, COUNT, ALMOST_FULL, ALMOST_EMPTY);
  modport slave(input D_IN, ENQ, DEQ, CLR,
                output D_OUT, FULL_N, EMPTY_N, COUNT, ALMOST_FULL, ALMOST_EMPTY);
`endif
endinterface

// File: rtl/fifo_n_level.sv
// fifo_n_level: depth-N width-W synchronous FIFO with occupancy count and almost-full/empty flags
// Ports: CLK clock, RST sync active-high reset, f (fifo_n_level_if.slave) carrying
// D_IN/ENQ/DEQ/CLR in and D_OUT/FULL_N/EMPTY_N/COUNT/ALMOST_FULL/ALMOST_EMPTY out.
// Define FIFON_ERR_FLAGS_EN to add sticky OVF/UDF error flags.
module fifo_n_level #(
  parameter int width    = 1,
  parameter int depth    = 4,
  parameter int af_level = depth - 1,
  parameter int ae_level = 1,
  parameter bit guarded  = 1'b1
) (
  input logic CLK,
  input logic RST,
  fifo_n_level_if.slave f
);
  localparam int cw = $clog2(depth + 1);
  localparam int pw = $clog2(depth);
  localparam logic [cw-1:0] full_c = cw'(depth);
  localparam logic [cw-1:0] af_c = cw'(af_level);
  localparam logic [cw-1:0] ae_c = cw'(ae_level);
  localparam logic [pw-1:0] last_c = pw'(depth - 1);
  logic [width-1:0] mem [depth];
  logic [pw-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [cw-1:0] count;
  logic enq_ok, deq_ok;
  // a full FIFO still accepts ENQ when DEQ frees the head slot in the same edge
  assign deq_ok = f.DEQ && count != '0;
  assign enq_ok = f.ENQ && (count < full_c || f.DEQ);
  // explicit wrap so non-power-of-two depths stay inside the array
  assign wr_nxt = wr_ptr == last_c ? '0 : wr_ptr + 1'b1;
  assign rd_nxt = rd_ptr == last_c ? '0 : rd_ptr + 1'b1;
  always_ff @(posedge CLK)
    if (RST || f.CLR) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq_ok) wr_ptr <= wr_nxt;
      if (deq_ok) rd_ptr <= rd_nxt;
      count <= count + cw'(enq_ok) - cw'(deq_ok);
    end
  always_ff @(posedge CLK)
    if (enq_ok && !RST && !f.CLR) mem[wr_ptr] <= f.D_IN;
  assign f.D_OUT        = mem[rd_ptr];
  assign f.COUNT        = count;
  assign f.FULL_N       = count < full_c;
  assign f.EMPTY_N      = count != '0;
  assign f.ALMOST_FULL  = count >= af_c;
  assign f.ALMOST_EMPTY = count <= ae_c;
`ifdef FIFON_ERR_FLAGS_EN
  logic ovf, udf;
  always_ff @(posedge CLK)
    if (RST || f.CLR) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (f.ENQ && !f.DEQ && count == full_c) ovf <= 1'b1;
      if (f.DEQ && count == '0) udf <= 1'b1;
    end
  assign f.OVF = ovf;
  assign f.UDF = udf;
`endif
`ifndef SYNTHESIS
  always_ff @(posedge CLK)
    if (!RST) begin
      if (f.DEQ && count == '0) $warning("Dequeuing from empty fifo");
      if (f.ENQ && count == full_c && (!f.DEQ || guarded)) $warning("Enqueuing to a full fifo");
    end
`endif
endmodule

// File: tb/tb_fifo_n_level.sv
// tb_fifo_n_level: directed scoreboard bench for fifo_n_level (width 8, depth 5)
module tb_fifo_n_level;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  fifo_n_level_if #(.width(8), .depth(5)) bus ();
  fifo_n_level #(.width(8), .depth(5)) dut (.CLK(CLK), .RST(RST), .f(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask
  always @(negedge CLK)
    if (!RST && !bus.CLR && bus.DEQ && bus.EMPTY_N) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop unexpected dequeue of %0h", bus.D_OUT);
      end else begin
        logic [7:0] v;
        v = exp_q.pop_front();
        if (bus.D_OUT !== v) begin
          errors++;
          $display("FAIL pop got %0h want %0h", bus.D_OUT, v);
        end
      end
    end
  task automatic step(input logic e, input logic d, input logic c, input logic [7:0] din);
    bus.ENQ = e;
    bus.DEQ = d;
    bus.CLR = c;
    bus.D_IN = din;
    @(posedge CLK);
    #1;
    bus.ENQ = 1'b0;
    bus.DEQ = 1'b0;
    bus.CLR = 1'b0;
  endtask
  task automatic push_step(input logic d, input logic [7:0] din);
    exp_q.push_back(din);
    step(1'b1, d, 1'b0, din);
  endtask
  initial begin
    bus.ENQ = 1'b0;
    bus.DEQ = 1'b0;
    bus.CLR = 1'b0;
    bus.D_IN = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("rst_count", 32'(bus.COUNT), 0);
    chk("rst_full_n", 32'(bus.FULL_N), 1);
    chk("rst_empty_n", 32'(bus.EMPTY_N), 0);
    chk("rst_af", 32'(bus.ALMOST_FULL), 0);
    chk("rst_ae", 32'(bus.ALMOST_EMPTY), 1);
`ifdef FIFON_ERR_FLAGS_EN
    chk("rst_ovf", 32'(bus.OVF), 0);
    chk("rst_udf", 32'(bus.UDF), 0);
`endif
    for (int i = 0; i < 5; i++) begin
      push_step(1'b0, 8'(8'h11 + i));
      chk("fill_count", 32'(bus.COUNT), 32'(i + 1));
      chk("fill_af", 32'(bus.ALMOST_FULL), 32'(i + 1 >= 4));
      chk("fill_ae", 32'(bus.ALMOST_EMPTY), 32'(i + 1 <= 1));
      chk("fill_dout", 32'(bus.D_OUT), 32'h11);
    end
    chk("full_n_low", 32'(bus.FULL_N), 0);
    push_step(1'b1, 8'h77);
    chk("full_ed_count", 32'(bus.COUNT), 5);
    chk("full_ed_head", 32'(bus.D_OUT), 32'h12);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("drain_empty_n", 32'(bus.EMPTY_N), 0);
    chk("drain_count", 32'(bus.COUNT), 0);
    push_step(1'b0, 8'hA0);
    for (int i = 1; i < 7; i++) begin
      push_step(1'b1, 8'(8'hA0 + i));
      chk("wrap_count", 32'(bus.COUNT), 1);
      chk("wrap_head", 32'(bus.D_OUT), 32'(8'hA0 + i));
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("wrap_empty_n", 32'(bus.EMPTY_N), 0);
`ifdef FIFON_ERR_FLAGS_EN
    chk("udf_pre", 32'(bus.UDF), 0);
`endif
    push_step(1'b1, 8'h3C);
    chk("empty_ed_count", 32'(bus.COUNT), 1);
    chk("empty_ed_dout", 32'(bus.D_OUT), 32'h3C);
`ifdef FIFON_ERR_FLAGS_EN
    chk("udf_set", 32'(bus.UDF), 1);
`endif
    push_step(1'b0, 8'h41);
    push_step(1'b0, 8'h42);
    chk("pre_clr_count", 32'(bus.COUNT), 3);
    exp_q.delete();
    step(1'b1, 1'b0, 1'b1, 8'h99);
    chk("clr_count", 32'(bus.COUNT), 0);
    chk("clr_empty_n", 32'(bus.EMPTY_N), 0);
    chk("clr_ae", 32'(bus.ALMOST_EMPTY), 1);
`ifdef FIFON_ERR_FLAGS_EN
    chk("clr_udf", 32'(bus.UDF), 0);
    chk("clr_ovf", 32'(bus.OVF), 0);
`endif
    push_step(1'b0, 8'h55);
    chk("post_clr_dout", 32'(bus.D_OUT), 32'h55);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) push_step(1'b0, 8'(8'h01 + i));
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    chk("ovf_count", 32'(bus.COUNT), 5);
    chk("ovf_dout", 32'(bus.D_OUT), 32'h01);
    chk("ovf_full_n", 32'(bus.FULL_N), 0);
`ifdef FIFON_ERR_FLAGS_EN
    chk("ovf_set", 32'(bus.OVF), 1);
`endif
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
`ifdef FIFON_ERR_FLAGS_EN
    chk("ovf_hold", 32'(bus.OVF), 1);
`endif
    step(1'b0, 1'b0, 1'b1, 8'h00);
`ifdef FIFON_ERR_FLAGS_EN
    chk("ovf_clr", 32'(bus.OVF), 0);
`endif
    push_step(1'b0, 8'hB1);
    push_step(1'b0, 8'hB2);
    exp_q.delete();
    RST = 1'b1;
    step(1'b1, 1'b1, 1'b0, 8'hB3);
    RST = 1'b0;
    chk("midrst_count", 32'(bus.COUNT), 0);
    chk("midrst_empty_n", 32'(bus.EMPTY_N), 0);
    push_step(1'b0, 8'hC4);
    chk("midrst_dout", 32'(bus.D_OUT), 32'hC4);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_n_level.md
# fifo_n_level

Depth-N, width-W synchronous FIFO with occupancy count and programmable almost-full/almost-empty flags. Parametrised successor of the single-entry FIFO primitive in the BSV primitive library. Keeps the same ENQ/DEQ/FULL_N/EMPTY_N/CLR handshake, so Bluespec-generated wrappers can use it as a drop-in wherever more than one entry of elasticity is needed. Sits between producer and consumer rules in worker datapaths; the level flags drive upstream throttling.

## Interface
- width, 1: data bits per entry.
- depth, 4: number of entries; any integer ≥ 2, not restricted to powers of two.
- af_level, depth-1: ALMOST_FULL asserts when count ≥ af_level; legal range 1..depth.
- ae_level, 1: ALMOST_EMPTY asserts when count ≤ ae_level; legal range 0..depth-1.
- guarded, 1: 1 = an ENQ while full is a protocol error even if DEQ is also asserted; 0 = that case is legal. Affects only the error reporting, never the datapath.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- D_IN  in  width  enqueue data.
- ENQ  in  1  enqueue request.
- DEQ  in  1  dequeue request.
- CLR  in  1  synchronous flush.
- D_OUT  out  width  head-of-queue data; valid only while EMPTY_N = 1.
- FULL_N  out  1  1 = space available (count < depth).
- EMPTY_N  out  1  1 = data available (count > 0).
- COUNT  out  $clog2(depth+1)  current occupancy, 0..depth.
- ALMOST_FULL  out  1  count ≥ af_level.
- ALMOST_EMPTY  out  1  count ≤ ae_level.
- OVF, UDF  out  1 each  sticky error flags; present only with FIFON_ERR_FLAGS_EN (see Configuration).

## Operation
- Storage: register array of depth entries plus write pointer, read pointer and count register. Storage contents are not reset.
- Both pointers wrap from depth-1 to 0. This wrap applies to non-power-of-two depths as well.
- deq_ok = DEQ && count > 0.
- enq_ok = ENQ && (count < depth || DEQ).
- Consequence of enq_ok: when full, a simultaneous ENQ+DEQ performs both operations and count is unchanged.
- ENQ on full without DEQ: write dropped; state unchanged.
- DEQ on empty: ignored.
- ENQ+DEQ on empty: the enqueue is accepted and the dequeue is ignored; count becomes 1.
- Count update: +1 when only enq_ok; -1 when only deq_ok; unchanged when both or neither.
- Priority on each edge is RST > CLR > ENQ/DEQ.
  - CLR zeroes count and both pointers.
  - Any ENQ/DEQ in the CLR cycle is discarded.
- D_OUT = storage[rd_ptr], a combinational read of registered state. When empty, D_OUT holds stale data.
- FULL_N, EMPTY_N, ALMOST_FULL and ALMOST_EMPTY are decoded from the registered count only. They never depend on same-cycle ENQ/DEQ.
- Simulation-only checks (translate_off), active when RST = 0:
  - "Dequeuing from empty fifo" when DEQ && count == 0.
  - "Enqueuing to a full fifo" when ENQ && count == depth && (!DEQ || guarded).

## Timing
- Reset values, valid after the first edge with RST = 1:
  - COUNT = 0, FULL_N = 1, EMPTY_N = 0, ALMOST_FULL = 0 (af_level ≥ 1), ALMOST_EMPTY = 1.
  - OVF = UDF = 0 when compiled in.
  - D_OUT is undefined.
- Enqueue latency is 1 cycle. An enq_ok at edge k makes EMPTY_N, D_OUT and COUNT reflect the new entry immediately after edge k.
- Dequeue takes effect at the edge. After the edge, D_OUT shows the next entry, or stale data if the FIFO is now empty.
- Full throughput: one ENQ and one DEQ per cycle sustained at any occupancy from 1 to depth.
- RST asserted mid-stream: contents are discarded at that edge, with no partial transfer.

## Configuration
- FIFON_ERR_FLAGS_EN defined:
  - Adds the sticky OVF and UDF output ports.
  - OVF sets on the edge where ENQ is dropped: full, no DEQ, no CLR.
  - UDF sets on the edge where DEQ && count == 0 && !CLR.
  - Both clear only on RST or CLR.
- FIFON_ERR_FLAGS_EN undefined:
  - Ports and logic are absent.
  - Datapath behaviour is identical.
  - The simulation warnings remain in both builds.

## Test plan
- Reset, then fill: width = 8, depth = 5. Apply RST for 2 cycles, then ENQ 0x11..0x15 on consecutive cycles.
  - COUNT steps 1..5.
  - FULL_N = 0 after the 5th edge.
  - ALMOST_FULL rises at COUNT = 4.
  - D_OUT = 0x11 throughout.
- Drain and wrap: from full, DEQ 5 cycles, then ENQ 0xA0..0xA6 while simultaneously DEQ-ing from the 2nd cycle.
  - Order is preserved across the pointer wrap at index 4 → 0.
  - EMPTY_N = 0 after the last drain edge.
- Full with ENQ+DEQ: at COUNT = 5, assert ENQ = 0x77 and DEQ together.
  - COUNT stays 5.
  - Head advances.
  - 0x77 emerges 5 dequeues later.
  - Warning printed only when guarded = 1.
- Empty with ENQ+DEQ: at COUNT = 0, assert ENQ = 0x3C and DEQ together.
  - COUNT = 1, D_OUT = 0x3C.
  - UDF = 1 (flags build).
- CLR priority: at COUNT = 3, assert CLR with ENQ = 0x99.
  - COUNT = 0, EMPTY_N = 0, ALMOST_EMPTY = 1.
  - 0x99 is never output.
  - OVF and UDF cleared.
- Overflow flag (FIFON_ERR_FLAGS_EN): at COUNT = 5, assert ENQ without DEQ.
  - COUNT stays 5; the contents are unchanged.
  - OVF = 1 and holds until CLR.
